// File: rtl/uart_transmitter.sv
// uart_transmitter: UART transmitter (8N1, LSB first) fed by a small byte FIFO, 16x-style clken.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       tx_busy,
  output logic       tx_byte_done,
  output logic       tx
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickMax = TickW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // Byte FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;
  logic [7:0]      head;

  assign full = (count_q == CntFull);
  assign push = wr_en && !full;
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Serialiser
  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_pos_q, bit_pos_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = clken && (tick_q == TickMax);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_pos_d = bit_pos_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    // Tick counter only runs inside a frame; clken is ignored while idle.
    if (state_q != StIdle && clken) begin
      tick_d = bit_end ? '0 : tick_q + TickW'(1);
    end
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = head;
          tick_d    = '0;
          bit_pos_d = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^head;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_pos_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_pos_d = bit_pos_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_pos_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_pos_q <= bit_pos_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_byte_done = done_q;
  assign tx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed, table-driven bench for uart_transmitter (OVERSAMPLE=16, depth 4).
// Frame expectations follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_transmitter;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clken   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       full, tx_busy, tx_byte_done, tx;

  int errors = 0;
  int checks = 0;

  uart_transmitter #(
    .FIFO_DEPTH(4),
    .OVERSAMPLE(OS)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .clken       (clken),
    .wr_en       (wr_en),
    .din         (din),
    .full        (full),
    .tx_busy     (tx_busy),
    .tx_byte_done(tx_byte_done),
    .tx          (tx)
  );

  always #10 clk_50m = ~clk_50m;

  // line = {stop, d7..d0, start}, hand-written; par = even parity of data
  typedef struct packed {
    logic [7:0] data;
    logic [3:0] div;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int i);
    if (i < 9) return v.line[i];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return v.par;
`endif
    return 1'b1;
  endfunction

  // Observation c is taken at the negedge following posedge c-1; inputs for posedge c follow it.
  task automatic run_vec(input int n, input vec_t v);
    int d, first, c_done, done_seen, ctr;
    d         = int'(v.div);
    first     = ((2 + d - 1) / d) * d;
    c_done    = first + (OS * NB - 1) * d + 1;
    done_seen = 0;
    for (int c = 0; c <= c_done + 2; c++) begin
      @(negedge clk_50m);
      if (tx_byte_done) done_seen++;
      if (c == 2) check($sformatf("v%0d busy_after_load", n), tx_busy, 1);
      for (int i = 0; i < NB; i++) begin
        ctr = first + (OS * (i + 1) - 1) * d - (OS / 2) * d + 1;
        if (c == ctr) check($sformatf("v%0d bit%0d", n, i), tx, exp_bit(v, i));
      end
      if (c == c_done) begin
        check($sformatf("v%0d done_time", n), tx_byte_done, 1);
        check($sformatf("v%0d idle_after_done", n), tx_busy, 0);
      end
      wr_en = (c == 0);
      din   = v.data;
      clken = ((c % d) == 0);
    end
    check($sformatf("v%0d done_count", n), done_seen, 1);
  endtask

  task automatic run_idle();
    int bad_tx, bad_busy, bad_full, dones;
    bad_tx = 0; bad_busy = 0; bad_full = 0; dones = 0;
    clken = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_50m);
      if (tx !== 1'b1) bad_tx++;
      if (tx_busy !== 1'b0) bad_busy++;
      if (full !== 1'b0) bad_full++;
      if (tx_byte_done !== 1'b0) dones++;
    end
    check("idle tx_low_cycles", bad_tx, 0);
    check("idle busy_cycles", bad_busy, 0);
    check("idle full_cycles", bad_full, 0);
    check("idle done_pulses", dones, 0);
  endtask

  task automatic run_burst();
    logic [7:0] bytes [6];
    logic [7:0] rx [5];
    int p, dones, late_busy, last;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int k = 0; k < 5; k++) rx[k] = 8'h00;
    p = OS * NB + 1;
    last = OS * NB + 2 + p * 4;
    dones = 0; late_busy = 0;
    clken = 1'b1;
    for (int c = 0; c <= last + 100; c++) begin
      @(negedge clk_50m);
      if (tx_byte_done) dones++;
      if (c > last && (tx_busy || !tx)) late_busy++;
      if (c == 4) check("burst full_before_4th", full, 0);
      if (c == 5) check("burst full_after_4th", full, 1);
      if (c == 6) check("burst full_after_drop", full, 1);
      for (int k = 0; k < 5; k++) begin
        for (int i = 1; i <= 8; i++) begin
          if (c == p * k + OS * i + OS / 2 + 2) rx[k][i-1] = tx;
        end
        if (c == OS * NB + 2 + p * k) check($sformatf("burst done%0d", k), tx_byte_done, 1);
        if (k < 4 && c == OS * NB + 3 + p * k) check($sformatf("burst next_start%0d", k), tx, 0);
      end
      wr_en = (c < 6);
      din   = (c < 6) ? bytes[c] : 8'h00;
    end
    for (int k = 0; k < 5; k++) check($sformatf("burst byte%0d", k), rx[k], bytes[k]);
    check("burst done_count", dones, 5);
    check("burst no_frame_for_dropped", late_busy, 0);
  endtask

  task automatic run_reset_mid();
    logic [7:0] bytes [3];
    int bad;
    bytes = '{8'h3C, 8'h5A, 8'hC3};
    clken = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_50m);
      if (c == 40) check("rst pre_busy", tx_busy, 1);
      wr_en = (c < 3);
      din   = (c < 3) ? bytes[c] : 8'h00;
    end
    @(negedge clk_50m);
    rst_n = 1'b0;
    #1;
    check("rst tx_high", tx, 1);
    check("rst busy", tx_busy, 0);
    check("rst full", full, 0);
    check("rst done", tx_byte_done, 0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_50m);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_byte_done !== 1'b0) bad++;
    end
    check("rst no_frames_after", bad, 0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, div: 4'd1, line: 10'b1101001010, par: 1'b0};
    vecs[1] = '{data: 8'h00, div: 4'd4, line: 10'b1000000000, par: 1'b0};
    vecs[2] = '{data: 8'hFF, div: 4'd1, line: 10'b1111111110, par: 1'b0};
    vecs[3] = '{data: 8'h07, div: 4'd1, line: 10'b1000001110, par: 1'b1};
    vecs[4] = '{data: 8'h03, div: 4'd1, line: 10'b1000000110, par: 1'b0};
    vecs[5] = '{data: 8'h3C, div: 4'd2, line: 10'b1001111000, par: 1'b0};

    repeat (3) @(negedge clk_50m);
    check("reset tx", tx, 1);
    check("reset busy", tx_busy, 0);
    rst_n = 1'b1;

    run_idle();
    for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);
    run_burst();
    run_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
